// File: rtl/queue_ctrl.sv
// Sequencer between the word deserializer and the word queue: issues single-cycle
// enqueue/dequeue commands, at most one per two cycles, with dequeue taking priority.
module queue_ctrl #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clock_1MHz,
  input  logic              rst,
  input  logic              deser_valid_in,
  input  logic [WORD_W-1:0] deser_data_in,
  output logic              deser_ack_out,
  input  logic              dequeue_in,
  input  logic [LEN_W-1:0]  q_len_in,
  input  logic [WORD_W-1:0] q_data_in,
  output logic              q_enqueue_out,
  output logic              q_dequeue_out,
  output logic [WORD_W-1:0] q_data_out,
  output logic              status_out,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid_out,
  output logic              underflow_out
);

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENQ    = 2'd1,
    S_DEQ    = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_deq_prev;
  logic              r_deq_pending;
  logic              r_enq;
  logic              r_deq;
  logic              r_underflow;
  logic [WORD_W-1:0] r_q_data;
  logic [WORD_W-1:0] r_data;

  logic w_deq_rise;
  logic w_has_room;
  logic w_not_empty;
  logic w_enq_nxt;
  logic w_deq_nxt;
  logic w_uf_nxt;
  logic w_pend_clr;

  assign w_deq_rise  = dequeue_in & ~r_deq_prev;
  assign w_has_room  = (q_len_in < DEPTH_L);
  assign w_not_empty = (q_len_in != '0);

  // State register
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next-cycle pulse decode; dequeue outranks enqueue in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_enq_nxt   = 1'b0;
    w_deq_nxt   = 1'b0;
    w_uf_nxt    = 1'b0;
    w_pend_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_deq_pending && w_not_empty) begin
          w_state_nxt = S_DEQ;
          w_deq_nxt   = 1'b1;
          w_pend_clr  = 1'b1;
        end else if (r_deq_pending) begin
          w_uf_nxt    = 1'b1;
          w_pend_clr  = 1'b1;
        end else if (deser_valid_in && w_has_room) begin
          w_state_nxt = S_ENQ;
          w_enq_nxt   = 1'b1;
        end
      end
      S_ENQ:    w_state_nxt = S_SETTLE;
      S_DEQ:    w_state_nxt = S_SETTLE;
      S_SETTLE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered pulses, data holding registers and dequeue request tracking
  always_ff @(posedge clock_1MHz or posedge rst) begin
    if (rst) begin
      r_deq_prev    <= 1'b1;
      r_deq_pending <= 1'b0;
      r_enq         <= 1'b0;
      r_deq         <= 1'b0;
      r_underflow   <= 1'b0;
      r_q_data      <= '0;
      r_data        <= '0;
    end else begin
      r_deq_prev  <= dequeue_in;
      r_enq       <= w_enq_nxt;
      r_deq       <= w_deq_nxt;
      r_underflow <= w_uf_nxt;
      if (w_deq_rise)      r_deq_pending <= 1'b1;
      else if (w_pend_clr) r_deq_pending <= 1'b0;
      if (w_enq_nxt) r_q_data <= deser_data_in;
      if (w_deq_nxt) r_data   <= q_data_in;
    end
  end

  assign q_enqueue_out  = r_enq;
  assign deser_ack_out  = r_enq;
  assign q_dequeue_out  = r_deq;
  assign data_valid_out = r_deq;
  assign underflow_out  = r_underflow;
  assign q_data_out     = r_q_data;
  assign data_out       = r_data;
  assign status_out     = (r_state == S_IDLE) && w_has_room;

endmodule
